// File: rtl/pipe_csa_addsub_pkg.sv
// Shared constants and stage-1 control record for the two-stage
// conditional-sum adder/subtractor.
package pipe_csa_addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LO_W  = DEF_WIDTH / 2;

  // Control part of the stage-1 payload; the segment sums ride alongside
  // as WIDTH-dependent registers in the top.
  typedef struct packed {
    logic lo_cout;
    logic hi_cout0;
    logic hi_cout1;
    logic a_msb;
    logic b_msb;
  } s1_ctl_t;

endpackage

// File: rtl/pipe_csa_addsub_rca.sv
// Parametrised ripple-carry adder used for the low segment and both
// high-segment carry candidates.
module rca_nbit #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[N];

endmodule

// File: rtl/pipe_csa_addsub.sv
// Two-stage conditional-sum adder/subtractor with valid/ready handshake:
// stage 1 computes low sum and both high candidates, stage 2 selects.
module pipe_csa_addsub
  import pipe_csa_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0] eff_b;
  logic             cin0;
  logic [LO_W-1:0]  lo_sum;
  logic [HI_W-1:0]  hi_sum0, hi_sum1;
  s1_ctl_t          ctl_d;

  // Subtract is A + ~B + 1, so the carry-in is forced high.
  assign eff_b = in_sub ? ~in_b : in_b;
  assign cin0  = in_sub | in_cin;

  rca_nbit #(.N(LO_W)) u_lo (
    .a(in_a[LO_W-1:0]), .b(eff_b[LO_W-1:0]), .cin(cin0),
    .sum(lo_sum), .cout(ctl_d.lo_cout)
  );

  rca_nbit #(.N(HI_W)) u_hi0 (
    .a(in_a[WIDTH-1:LO_W]), .b(eff_b[WIDTH-1:LO_W]), .cin(1'b0),
    .sum(hi_sum0), .cout(ctl_d.hi_cout0)
  );

  rca_nbit #(.N(HI_W)) u_hi1 (
    .a(in_a[WIDTH-1:LO_W]), .b(eff_b[WIDTH-1:LO_W]), .cin(1'b1),
    .sum(hi_sum1), .cout(ctl_d.hi_cout1)
  );

  assign ctl_d.a_msb = in_a[WIDTH-1];
  assign ctl_d.b_msb = eff_b[WIDTH-1];

  logic            s1_valid, s2_valid;
  logic [LO_W-1:0] s1_lo;
  logic [HI_W-1:0] s1_hi0, s1_hi1;
  s1_ctl_t         s1_ctl;
  logic            s1_load, s2_load;

  assign in_ready  = !s1_valid | !s2_valid | out_ready;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s1_valid & (!s2_valid | out_ready);
  assign out_valid = s2_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi0   <= '0;
      s1_hi1   <= '0;
      s1_ctl   <= '0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s1_load) begin
        s1_lo  <= lo_sum;
        s1_hi0 <= hi_sum0;
        s1_hi1 <= hi_sum1;
        s1_ctl <= ctl_d;
      end
    end
  end

  logic [HI_W-1:0]  hi_sel;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;

  assign hi_sel = s1_ctl.lo_cout ? s1_hi1 : s1_hi0;
  assign cout_d = s1_ctl.lo_cout ? s1_ctl.hi_cout1 : s1_ctl.hi_cout0;
  assign sum_d  = {hi_sel, s1_lo};
  assign ovf_d  = (s1_ctl.a_msb == s1_ctl.b_msb) & (sum_d[WIDTH-1] != s1_ctl.a_msb);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      if (s2_load)        s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
      if (s2_load) begin
        out_sum  <= sum_d;
        out_cout <= cout_d;
        out_ovf  <= ovf_d;
        out_zero <= (sum_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_csa_addsub.sv
// Bench: directed cases on a 32-bit instance, randomised throttled traffic
// on 8/3 and 64/32 instances against an arithmetic reference model.
module tb_pipe_csa_addsub;

  localparam int NRND = 10000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  // Reference: plain (WIDTH+1)-bit arithmetic, carry read from bit WIDTH.
  function automatic exp_t ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin);
    exp_t r;
    logic [64:0] mask, full;
    logic [63:0] eb;
    mask   = (65'd1 << w) - 65'd1;
    eb     = sub ? ~b : b;
    full   = ({1'b0, a} & mask) + ({1'b0, eb} & mask) + (sub ? 65'd1 : {64'd0, cin});
    r.cout = full[w];
    r.sum  = full[63:0] & mask[63:0];
    r.ovf  = (a[w-1] == eb[w-1]) && (r.sum[w-1] != a[w-1]);
    r.zero = (r.sum == 64'd0);
    r.acc  = 0;
    return r;
  endfunction

  // 32-bit directed instance
  logic        iv32 = 0, ordy32 = 1, sub32 = 0, cin32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        ir32, ov32, cout32, ovf32, zero32;
  logic [31:0] sum32;

  pipe_csa_addsub u_d32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_sub(sub32), .in_cin(cin32),
    .out_valid(ov32), .out_ready(ordy32), .out_sum(sum32), .out_cout(cout32),
    .out_ovf(ovf32), .out_zero(zero32)
  );

  // Random instances: index 0 = 8/3, index 1 = 64/32
  logic        r_iv [2];
  logic        r_ir [2];
  logic        r_ov [2];
  logic        r_ordy [2];
  logic        r_sub [2];
  logic        r_cin [2];
  logic        r_cout [2];
  logic        r_ovf [2];
  logic        r_zero [2];
  logic [7:0]  a8, b8, sum8;
  logic [63:0] a64, b64, sum64;

  pipe_csa_addsub #(.WIDTH(8), .LO_W(3)) u_d8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(r_iv[0]), .in_ready(r_ir[0]), .in_a(a8), .in_b(b8), .in_sub(r_sub[0]), .in_cin(r_cin[0]),
    .out_valid(r_ov[0]), .out_ready(r_ordy[0]), .out_sum(sum8), .out_cout(r_cout[0]),
    .out_ovf(r_ovf[0]), .out_zero(r_zero[0])
  );

  pipe_csa_addsub #(.WIDTH(64), .LO_W(32)) u_d64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(r_iv[1]), .in_ready(r_ir[1]), .in_a(a64), .in_b(b64), .in_sub(r_sub[1]), .in_cin(r_cin[1]),
    .out_valid(r_ov[1]), .out_ready(r_ordy[1]), .out_sum(sum64), .out_cout(r_cout[1]),
    .out_ovf(r_ovf[1]), .out_zero(r_zero[1])
  );

  // One op on an idle 32-bit pipe with out_ready high; exp = {cout,ovf,zero,sum}.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic cin, input logic [34:0] exp);
    @(posedge clock); #1;
    a32 = a; b32 = b; sub32 = sub; cin32 = cin; iv32 = 1'b1;
    @(posedge clock); #1;
    iv32 = 1'b0;
    chk({tag, "_lat1"}, 128'(ov32), 128'(1'b0));
    @(posedge clock); #1;
    chk({tag, "_lat2"}, 128'(ov32), 128'(1'b1));
    chk(tag, 128'({cout32, ovf32, zero32, sum32}), 128'(exp));
  endtask

  logic [31:0] bpa [5];
  logic [31:0] bpb [5];
  exp_t        bpe [5];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          issued [2];

  initial begin
    int idx, got;
    for (int k = 0; k < 2; k++) begin
      r_iv[k] = 0; r_ordy[k] = 1; r_sub[k] = 0; r_cin[k] = 0; issued[k] = 0;
    end
    a8 = 0; b8 = 0; a64 = 0; b64 = 0;

    #12;
    chk("rst32_hs", 128'({ov32, ir32}), 128'(2'b01));
    chk("rst32_out", 128'({cout32, ovf32, zero32, sum32}), 128'(0));
    chk("rst8_hs", 128'({r_ov[0], r_ir[0]}), 128'(2'b01));
    chk("rst64_hs", 128'({r_ov[1], r_ir[1]}), 128'(2'b01));
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    op32("add_carry", 32'h0000FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h00010000});
    op32("sub_zero",  32'd5, 32'd5, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 32'h00000000});
    op32("sub_borrow", 32'd0, 32'd1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFF});
    op32("add_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000});
    op32("sub_ovf", 32'h80000000, 32'd1, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 32'h7FFFFFFF});
    op32("add_cin", 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h00000000});

    // Backpressure: five offers, consumer stalled for the first four cycles.
    for (int i = 0; i < 5; i++) begin
      bpa[i] = 32'h10000000 * i + i;
      bpb[i] = 32'(i * 3 + 1);
      bpe[i] = ref_op(32, {32'd0, bpa[i]}, {32'd0, bpb[i]}, 1'b0, 1'(i));
    end
    @(posedge clock); #1;
    idx = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      iv32 = (idx < 5);
      if (idx < 5) begin a32 = bpa[idx]; b32 = bpb[idx]; sub32 = 1'b0; cin32 = 1'(idx); end
      ordy32 = (c >= 4);
      @(negedge clock);
      if (c == 2 || c == 3) begin
        chk("bp_stall", 128'({ir32, idx}), 128'({1'b0, 32'd2}));
        chk("bp_hold", 128'({ov32, sum32}), 128'({1'b1, bpe[0].sum[31:0]}));
      end
      if (iv32 && ir32) idx++;
      if (ov32 && ordy32) begin
        if (got < 5)
          chk("bp_res", 128'({cout32, ovf32, zero32, sum32}),
              128'({bpe[got].cout, bpe[got].ovf, bpe[got].zero, bpe[got].sum[31:0]}));
        got++;
      end
      @(posedge clock); #1;
    end
    iv32 = 1'b0; ordy32 = 1'b1;
    chk("bp_count", 128'(got), 128'(5));

    // Reset mid-stream with two transactions in flight.
    a32 = 32'd100; b32 = 32'd1; sub32 = 0; cin32 = 0; iv32 = 1'b1;
    @(posedge clock); #1;
    a32 = 32'd200;
    @(posedge clock); #1;
    iv32 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_hs", 128'({ov32, ir32}), 128'(2'b01));
    chk("rst_mid_out", 128'({cout32, ovf32, zero32, sum32}), 128'(0));
    #1 reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("rst_no_stale", 128'(ov32), 128'(1'b0));
    end
    @(posedge clock); #1;
    op32("post_rst", 32'h12345678, 32'h11111111, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, 32'h01234567});

    // Random throttled traffic on both random instances.
    cyc = 0;
    while (!(issued[0] == NRND && issued[1] == NRND && q0.size() == 0 && q1.size() == 0)
           && cyc < 60000) begin
      for (int k = 0; k < 2; k++) begin
        r_iv[k]   = (issued[k] < NRND) && ($urandom_range(3) != 0);
        r_ordy[k] = ($urandom_range(3) != 0);
        r_sub[k]  = 1'($urandom_range(1));
        r_cin[k]  = 1'($urandom_range(1));
      end
      a8 = 8'($urandom); b8 = 8'($urandom);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      if ($urandom_range(7) == 0) b8 = a8;
      if ($urandom_range(7) == 0) b64 = a64;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        exp_t f, e;
        int sz;
        logic ev, er;
        logic [63:0] gs, ua, ub;
        sz = (k == 0) ? q0.size() : q1.size();
        f = ref_op(8, 64'd0, 64'd0, 1'b0, 1'b0);
        if (sz > 0) begin
          if (k == 0) f = q0[0]; else f = q1[0];
        end
        er = (sz < 2) || r_ordy[k];
        ev = (sz > 0) && (cyc - f.acc >= 2);
        chk("rnd_hs", 128'({r_ov[k], r_ir[k]}), 128'({ev, er}));
        if (r_ov[k] && r_ordy[k] && sz > 0) begin
          gs = (k == 0) ? {56'd0, sum8} : sum64;
          chk("rnd_res", 128'({r_cout[k], r_ovf[k], r_zero[k], gs}),
              128'({f.cout, f.ovf, f.zero, f.sum}));
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (r_iv[k] && r_ir[k]) begin
          ua = (k == 0) ? {56'd0, a8} : a64;
          ub = (k == 0) ? {56'd0, b8} : b64;
          e = ref_op((k == 0) ? 8 : 64, ua, ub, r_sub[k], r_cin[k]);
          e.acc = cyc;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          issued[k]++;
        end
      end
      @(posedge clock);
      cyc++;
      #1;
    end
    chk("rnd_timeout", 128'(cyc >= 60000), 128'(0));
    chk("rnd_issued", 128'({issued[0], issued[1]}), 128'({NRND, NRND}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
